// File: rtl/pm_control.sv
// rtl/pm_control.sv - picoMips multi-cycle sequencer: fetch/decode/exec FSM driving ALU, register file and PC
// Strobes are registered so they are glitch-free and high only during EXEC.
module pm_control #(
  parameter int PW = 6
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [15:0]   Instr,
  input  logic [7:0]    ACC,
  input  logic          Go,
  output logic [PW-1:0] PC,
  output logic [7:0]    Imm,
  output logic [2:0]    RegAddr,
  output logic          RegWE,
  output logic          WE,
  output logic          SelSW,
  output logic          SelImm,
  output logic          SelRegData,
  output logic          UseMul,
  output logic          UseACC,
  output logic          Halted
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LDI    = 4'h1;
  localparam logic [3:0] OP_LDSW   = 4'h2;
  localparam logic [3:0] OP_LDR    = 4'h3;
  localparam logic [3:0] OP_ADDI   = 4'h4;
  localparam logic [3:0] OP_ADDR   = 4'h5;
  localparam logic [3:0] OP_ADDSW  = 4'h6;
  localparam logic [3:0] OP_MULI   = 4'h7;
  localparam logic [3:0] OP_STR    = 4'h8;
  localparam logic [3:0] OP_JMP    = 4'h9;
  localparam logic [3:0] OP_BZ     = 4'hA;
  localparam logic [3:0] OP_BNEG   = 4'hB;
  localparam logic [3:0] OP_WAITGO = 4'hC;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // Strobe vector order: {RegWE, WE, SelSW, SelImm, SelRegData, UseMul, UseACC}
  function automatic logic [6:0] decode_strobes(input logic [3:0] op);
    logic [6:0] s;
    case (op)
      OP_LDI:   s = 7'b0101000;
      OP_LDSW:  s = 7'b0110000;
      OP_LDR:   s = 7'b0100100;
      OP_ADDI:  s = 7'b0101001;
      OP_ADDR:  s = 7'b0100101;
      OP_ADDSW: s = 7'b0110001;
      OP_MULI:  s = 7'b0100011;
      OP_STR:   s = 7'b1000000;
      default:  s = 7'b0000000;
    endcase
    return s;
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [6:0]    strb_q, strb_d;
  logic          armed_q, armed_d;
  logic [3:0]    op;
  logic [PW-1:0] pc_inc;
  logic [PW-1:0] target;
  logic          unused_rsvd;

  assign op          = ir_q[15:12];
  assign pc_inc      = pc_q + PW'(1);
  assign target      = ir_q[PW-1:0];
  assign unused_rsvd = ir_q[11];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      strb_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      strb_q  <= strb_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    strb_d  = '0;
    armed_d = armed_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = Instr;
        strb_d  = decode_strobes(Instr[15:12]);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_JMP:  pc_d = target;
          OP_BZ:   pc_d = (ACC == 8'h00) ? target : pc_inc;
          OP_BNEG: pc_d = ACC[7] ? target : pc_inc;
          OP_WAITGO: begin
            // Go must be seen low before a press counts, so a held button is ignored.
            armed_d = 1'b0;
            state_d = S_WAIT_HI;
          end
          OP_HALT: state_d = S_HALT;
          default: pc_d = pc_inc;
        endcase
      end
      S_WAIT_HI: begin
        if (!Go) armed_d = 1'b1;
        if (armed_q && Go) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!Go) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign PC      = pc_q;
  assign Imm     = ir_q[7:0];
  assign RegAddr = ir_q[10:8];
  assign {RegWE, WE, SelSW, SelImm, SelRegData, UseMul, UseACC} = strb_q;
  assign Halted  = (state_q == S_HALT);

endmodule
